// File: rtl/mem_responder.sv
// mem_responder: memory-side responder of the CPU memory port.
// It serves one request at a time. The request is accepted in IDLE and its
// address, data and wren are latched. The FSM then waits WAIT_STATES cycles in
// BUSY, performs the access, and raises ack for one cycle while in RESP.
// Targets are word RAM below IO_BASE and a small I/O window at or above it.
//
// Handshake: req is a level request. The initiator holds req high until it
// samples ack=1 and then drops it. A req that is still high when the FSM is
// back in IDLE starts a new access. req is ignored in BUSY and RESP.
// address, data and wren are sampled only on the edge that accepts req in IDLE.
module mem_responder #(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [15:0] IO_BASE     = 16'hFF00
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    input  logic        wren,
    input  logic [15:0] address,
    input  logic [15:0] data,
    output logic        ack,
    output logic [15:0] q,
    output logic [15:0] io_out,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t      state;
    state_t      state_next;
    logic [3:0]  wcnt;
    logic [15:0] lat_addr;
    logic [15:0] lat_data;
    logic        lat_wren;
    logic [15:0] cyc_cnt;
    logic [15:0] ram [2**ADDR_W];

    logic        perform;
    logic        ram_sel;
    logic        io_out_sel;
    logic        io_cnt_sel;

    assign state_dbg = state;

    // Access strobe and address decode of the latched request
    always_comb begin
        perform    = (state == BUSY) && (wcnt == 4'd0);
        ram_sel    = (lat_addr < IO_BASE);
        io_out_sel = (lat_addr == IO_BASE);
        io_cnt_sel = (lat_addr == IO_BASE + 16'd1);
    end

    // Next-state logic: accept in IDLE, count wait states in BUSY, one RESP cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = BUSY;
            BUSY:    if (wcnt == 4'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Request latches, wait counter, free-running cycle counter, ack, q and io_out
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wcnt     <= 4'd0;
            lat_addr <= 16'd0;
            lat_data <= 16'd0;
            lat_wren <= 1'b0;
            cyc_cnt  <= 16'd0;
            ack      <= 1'b0;
            q        <= 16'd0;
            io_out   <= 16'd0;
        end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
            // ack follows the perform edge by exactly one cycle, which is the RESP cycle
            ack     <= perform;
            if (state == IDLE && req) begin
                lat_addr <= address;
                lat_data <= data;
                lat_wren <= wren;
                wcnt     <= WAIT_INIT;
            end else if (state == BUSY && wcnt != 4'd0) begin
                wcnt <= wcnt - 4'd1;
            end
            if (perform) begin
                if (lat_wren) begin
                    if (io_out_sel) io_out <= lat_data;
                end else if (ram_sel) begin
                    q <= ram[lat_addr[ADDR_W-1:0]];
                end else if (io_out_sel) begin
                    q <= io_out;
                end else if (io_cnt_sel) begin
                    // Value before this edge's increment
                    q <= cyc_cnt;
                end else begin
                    q <= 16'd0;
                end
            end
        end
    end

    // RAM write port; contents are not reset, upper address bits alias
    always_ff @(posedge clock) begin
        if (perform && lat_wren && ram_sel) ram[lat_addr[ADDR_W-1:0]] <= lat_data;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with WAIT_STATES=1, one with WAIT_STATES=0.
module tb_mem_responder;

    logic        clock;
    logic        reset_n;
    logic        req, wren;
    logic [15:0] address, data;
    logic        ack;
    logic [15:0] q, io_out;
    logic [1:0]  state;
    logic        req0, wren0;
    logic [15:0] address0, data0;
    logic        ack0;
    logic [15:0] q0, io_out0;
    logic [1:0]  state0;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_responder #(.ADDR_W(8), .WAIT_STATES(1), .IO_BASE(16'hFF00)) u_dut (
        .clock(clock), .reset_n(reset_n), .req(req), .wren(wren),
        .address(address), .data(data), .ack(ack), .q(q), .io_out(io_out),
        .state_dbg(state)
    );

    mem_responder #(.ADDR_W(8), .WAIT_STATES(0), .IO_BASE(16'hFF00)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .req(req0), .wren(wren0),
        .address(address0), .data(data0), .ack(ack0), .q(q0), .io_out(io_out0),
        .state_dbg(state0)
    );

    // Clock and reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Driver: issue one access on u_dut from a negedge. Returns the read data and
    // the number of negedges after the accept edge until ack was seen (-1 on timeout).
    task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                             output logic [15:0] rq, output int lat);
        req = 1'b1; wren = w; address = a; data = d;
        lat = -1;
        rq  = 16'hxxxx;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clock);
            if (ack === 1'b1) begin
                lat = k;
                rq  = q;
                req = 1'b0;
            end
        end
        req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [15:0] rq;
        int lat;
        reset_n = 1'b0;
        req = 0; wren = 0; address = 0; data = 0;
        req0 = 0; wren0 = 0; address0 = 0; data0 = 0;
        repeat (3) @(negedge clock);
        tests_run++;
        if (ack !== 1'b0 || q !== 16'h0 || io_out !== 16'h0 || state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ack=%b q=%h io_out=%h state=%0d expected 0 0 0 0",
                     ack, q, io_out, state);
        end
        tests_run++;
        if (ack0 !== 1'b0 || q0 !== 16'h0 || io_out0 !== 16'h0 || state0 !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs_ws0: ack=%b q=%h io_out=%h state=%0d expected 0 0 0 0",
                     ack0, q0, io_out0, state0);
        end
        // Counter starts at 0: release, accept edge 0->1, wait edge 1->2, perform reads 2
        reset_n = 1'b1;
        do_access(1'b0, 16'hFF01, 16'h0, rq, lat);
        tests_run++;
        if (rq !== 16'd2) begin
            tests_failed++;
            $display("FAIL reset_cyc_cnt: got %h expected 0002", rq);
        end
    endtask

    task automatic test_ram_rw();
        logic [15:0] rq;
        logic [15:0] q_before;
        int lat;
        q_before = q;
        do_access(1'b1, 16'h0010, 16'hBEEF, rq, lat);
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("FAIL wr_latency: got %0d expected 3", lat);
        end
        tests_run++;
        if (q !== q_before) begin
            tests_failed++;
            $display("FAIL wr_keeps_q: got %h expected %h", q, q_before);
        end
        do_access(1'b0, 16'h0010, 16'h0, rq, lat);
        tests_run++;
        if (lat !== 3) begin
            tests_failed++;
            $display("FAIL rd_latency: got %0d expected 3", lat);
        end
        tests_run++;
        if (rq !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL rd_0010: got %h expected BEEF", rq);
        end
    endtask

    task automatic test_alias();
        logic [15:0] rq;
        int lat;
        do_access(1'b1, 16'h0005, 16'h1234, rq, lat);
        do_access(1'b0, 16'h0105, 16'h0, rq, lat);
        tests_run++;
        if (rq !== 16'h1234) begin
            tests_failed++;
            $display("FAIL alias_0105: got %h expected 1234", rq);
        end
    endtask

    task automatic test_io();
        logic [15:0] rq;
        int lat;
        do_access(1'b1, 16'hFF00, 16'h00A5, rq, lat);
        tests_run++;
        if (io_out !== 16'h00A5) begin
            tests_failed++;
            $display("FAIL io_out_write: got %h expected 00A5", io_out);
        end
        do_access(1'b0, 16'hFF00, 16'h0, rq, lat);
        tests_run++;
        if (rq !== 16'h00A5) begin
            tests_failed++;
            $display("FAIL io_out_read: got %h expected 00A5", rq);
        end
        do_access(1'b0, 16'hFF07, 16'h0, rq, lat);
        tests_run++;
        if (rq !== 16'h0000) begin
            tests_failed++;
            $display("FAIL io_unmapped_read: got %h expected 0000", rq);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] qa [2];
        int          ka [2];
        int          n;
        logic [15:0] rq;
        int lat;
        n = 0;
        req = 1'b1; wren = 1'b0; address = 16'hFF01; data = 16'h0;
        for (int k = 1; k <= 16 && n < 2; k++) begin
            @(negedge clock);
            if (ack === 1'b1) begin
                qa[n] = q;
                ka[n] = k;
                n++;
                if (n == 2) req = 1'b0;
            end
        end
        req = 1'b0;
        @(negedge clock);
        tests_run++;
        if (n !== 2) begin
            tests_failed++;
            $display("FAIL b2b_ack_count: got %0d expected 2", n);
        end else begin
            tests_run++;
            if (qa[1] - qa[0] !== 16'd4) begin
                tests_failed++;
                $display("FAIL b2b_cnt_delta: got %0d expected 4", qa[1] - qa[0]);
            end
            tests_run++;
            if (ka[0] !== 3 || ka[1] !== 7) begin
                tests_failed++;
                $display("FAIL b2b_ack_timing: got %0d,%0d expected 3,7", ka[0], ka[1]);
            end
        end
        // Writing the counter address is ignored: io_out and q stay as they were
        qa[0] = q;
        do_access(1'b1, 16'hFF01, 16'h1234, rq, lat);
        tests_run++;
        if (io_out !== 16'h00A5 || q !== qa[0] || lat !== 3) begin
            tests_failed++;
            $display("FAIL cnt_write_ignored: io_out=%h q=%h lat=%0d expected 00A5 %h 3",
                     io_out, q, lat, qa[0]);
        end
    endtask

    task automatic test_ws0_stream();
        int  n;
        logic prev;
        n = 0;
        prev = 1'b0;
        req0 = 1'b1; wren0 = 1'b0; address0 = 16'hFF07; data0 = 16'h0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (ack0 === 1'b1) begin
                n++;
                tests_run++;
                if (k % 3 != 2 || prev || q0 !== 16'h0) begin
                    tests_failed++;
                    $display("FAIL ws0_ack_slot: cycle %0d prev_ack=%b q=%h expected cycle%%3==2, 0, 0000",
                             k, prev, q0);
                end
            end
            prev = ack0;
        end
        req0 = 1'b0;
        @(negedge clock);
        tests_run++;
        if (n !== 4) begin
            tests_failed++;
            $display("FAIL ws0_ack_count: got %0d expected 4", n);
        end
    endtask

    // Start a write, then assert reset one cycle later while the FSM is still in BUSY
    task automatic abort_write(input logic [15:0] d, input string tag);
        req = 1'b1; wren = 1'b1; address = 16'h0020; data = d;
        @(negedge clock);
        tests_run++;
        if (state !== 2'd1) begin
            tests_failed++;
            $display("FAIL %s_busy: state=%0d expected 1", tag, state);
        end
        reset_n = 1'b0;
        req = 1'b0;
        #1;
        tests_run++;
        if (ack !== 1'b0 || io_out !== 16'h0 || q !== 16'h0 || state !== 2'd0) begin
            tests_failed++;
            $display("FAIL %s_cleared: ack=%b io_out=%h q=%h state=%0d expected 0 0 0 0",
                     tag, ack, io_out, q, state);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_reset_abort();
        logic [15:0] rq;
        int lat;
        do_access(1'b0, 16'h0010, 16'h0, rq, lat);
        tests_run++;
        if (q !== 16'hBEEF || io_out !== 16'h00A5) begin
            tests_failed++;
            $display("FAIL abort_precond: q=%h io_out=%h expected BEEF 00A5", q, io_out);
        end
        abort_write(16'hAAAA, "abort1");
        do_access(1'b1, 16'h0020, 16'h0000, rq, lat);
        do_access(1'b0, 16'h0020, 16'h0, rq, lat);
        tests_run++;
        if (rq !== 16'h0000 || lat !== 3) begin
            tests_failed++;
            $display("FAIL abort1_readback: q=%h lat=%0d expected 0000 3", rq, lat);
        end
        abort_write(16'h5555, "abort2");
        do_access(1'b0, 16'h0020, 16'h0, rq, lat);
        tests_run++;
        if (rq !== 16'h0000) begin
            tests_failed++;
            $display("FAIL abort2_no_write: got %h expected 0000", rq);
        end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_ram_rw();
        test_alias();
        test_io();
        test_back_to_back();
        test_ws0_stream();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
